add_seq64: RTL and testbench
============================

ADD_SEQ64 -- requirements
Module: add_seq64

Interface
REQ-001 Parameter SLICE_W, default 16, SHALL set the width of the single carry-lookahead adder slice reused every cycle.
REQ-002 Parameter SLICES, default 4, SHALL set the number of slices per operation; the operand width is W = SLICE_W*SLICES.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1 bit: operand set a, b, cin offered.
REQ-006 Port in_ready, output, 1 bit: block can accept an operand set this cycle.
REQ-007 Port a, input, W bits: addend A.
REQ-008 Port b, input, W bits: addend B.
REQ-009 Port cin, input, 1 bit: carry into slice 0.
REQ-010 Port out_valid, output, 1 bit: sum, cout (and ovf) valid.
REQ-011 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port sum, output, W bits: registered A+B+cin modulo 2^W.
REQ-013 Port cout, output, 1 bit: carry out of the top slice.
REQ-014 Port busy, output, 1 bit: high in RUN.
REQ-015 Port slice_idx, output, clog2(SLICES) bits: index of the slice being computed.

Function
REQ-016 The block SHALL implement states IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 exactly in IDLE; a transfer occurs when in_valid and in_ready are both 1.
REQ-018 On a transfer the block SHALL register a, b and cin, clear slice_idx to 0, and go to RUN.
REQ-019 Each RUN cycle SHALL add slice slice_idx of A and B plus the stored carry using generate/propagate lookahead.
REQ-020 Each RUN cycle SHALL write the SLICE_W-bit result into sum[slice_idx*SLICE_W +: SLICE_W] and store the slice carry-out as the next carry.
REQ-021 slice_idx SHALL increment in RUN; after the cycle with slice_idx = SLICES-1, the block SHALL load cout and go to DONE.
REQ-022 Latency SHALL be exactly SLICES cycles from the transfer edge to out_valid = 1 (4 cycles by default).
REQ-023 out_valid SHALL be 1 exactly in DONE; sum, cout and ovf SHALL be held stable until the result is accepted.
REQ-024 In DONE with out_ready = 1, the block SHALL return to IDLE on that edge; back-to-back issue is not supported, so the next transfer occurs at the earliest one cycle later.
REQ-025 in_valid SHALL be ignored in RUN and DONE; a, b and cin SHALL be sampled only on the transfer edge.
REQ-026 Carry SHALL propagate across slices only through the stored carry register; there SHALL be no combinational path from a, b or cin to any output.
REQ-027 Carry-chain wrap: when A = 2^W-1, B = 0 and cin = 1, the carry SHALL ripple through every slice, giving sum = 0 and cout = 1.

Reset
REQ-028 While reset = 1 the block SHALL enter IDLE and SHALL set in_ready = 0, out_valid = 0, busy = 0, slice_idx = 0, sum = 0, cout = 0 and ovf = 0.
REQ-029 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation without producing out_valid, and the partial result SHALL be discarded.
REQ-031 Reset SHALL take priority over a transfer or acceptance in the same cycle.

Configuration
REQ-032 When macro ADD_SEQ64_OVF_EN is defined, the block SHALL add port ovf (output, 1 bit), set in DONE to the carry into the MSB XOR cout, which is the signed two's-complement overflow.
REQ-033 When ADD_SEQ64_OVF_EN is undefined, the block SHALL have no ovf port or logic, and all other behaviour SHALL be unchanged.

Verification
REQ-034 After reset, the bench SHALL offer a=1, b=2, cin=0 -> in_ready=1, 4 cycles later out_valid=1, sum=3, cout=0.
REQ-035 The bench SHALL offer a=all-ones, b=0, cin=1 -> sum=0, cout=1, and slice_idx sequences 0,1,2,3 with busy=1.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum and cout stable, in_ready stays 0; asserting out_ready returns the block to IDLE.
REQ-037 The bench SHALL assert reset when slice_idx=2 -> next cycle: IDLE, out_valid=0, sum=0; a new operation then completes correctly.
REQ-038 With ADD_SEQ64_OVF_EN defined, the bench SHALL offer a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-039 The bench SHALL toggle in_valid during RUN with different operands -> the result reflects only the operands captured on the transfer edge.

Source files
------------

// File: rtl/add_seq64.sv
// add_seq64 -- sequential W-bit adder that reuses one SLICE_W-bit carry-lookahead
// slice per cycle. An operation is accepted in IDLE, takes SLICES RUN cycles
// (slice 0 first), and its result is then held in DONE until out_ready.
// Optional feature: define ADD_SEQ64_OVF_EN to add the signed overflow output ovf.
module add_seq64 #(
    parameter int SLICE_W = 16,
    parameter int SLICES  = 4,
    localparam int W      = SLICE_W * SLICES,
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sum,
    output logic             cout,
`ifdef ADD_SEQ64_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic [IDX_W-1:0] slice_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic                 carry_r;
    logic                 xfer_s;
    logic                 last_s;
    int                   idx_int_s;
    logic [SLICE_W-1:0]   slice_a_s;
    logic [SLICE_W-1:0]   slice_b_s;
    logic [SLICE_W:0]     slice_res_s;

    // Parallel-prefix (Kogge-Stone style) carry-lookahead add of one slice.
    // Returns {carry_out, sum}.
    function automatic logic [SLICE_W:0] cla_slice(
        input logic [SLICE_W-1:0] x,
        input logic [SLICE_W-1:0] y,
        input logic               c0
    );
        logic [SLICE_W-1:0] p;
        logic [SLICE_W-1:0] gg;
        logic [SLICE_W-1:0] pg;
        logic [SLICE_W-1:0] gn;
        logic [SLICE_W-1:0] pn;
        logic [SLICE_W-1:0] c;
        logic               co;
        p  = x ^ y;
        gg = x & y;
        pg = p;
        for (int d = 1; d < SLICE_W; d = d * 2) begin
            gn = gg;
            pn = pg;
            for (int i = 0; i < SLICE_W; i++) begin
                if (i >= d) begin
                    gn[i] = gg[i] | (pg[i] & gg[i-d]);
                    pn[i] = pg[i] & pg[i-d];
                end else begin
                    gn[i] = gg[i];
                    pn[i] = pg[i];
                end
            end
            gg = gn;
            pg = pn;
        end
        // gg[i]/pg[i] now span bits 0..i, so every carry is one AND-OR away from c0
        c[0] = c0;
        for (int i = 1; i < SLICE_W; i++) begin
            c[i] = gg[i-1] | (pg[i-1] & c0);
        end
        co = gg[SLICE_W-1] | (pg[SLICE_W-1] & c0);
        return {co, p ^ c};
    endfunction

    // Handshake qualifiers and the current slice operands (registered operands only).
    always_comb begin
        in_ready    = (state_r == IDLE) && !reset;
        out_valid   = (state_r == DONE);
        busy        = (state_r == RUN);
        xfer_s      = in_valid && in_ready;
        last_s      = (slice_idx == IDX_W'(SLICES - 1));
        idx_int_s   = int'(slice_idx);
        slice_a_s   = a_r[idx_int_s*SLICE_W +: SLICE_W];
        slice_b_s   = b_r[idx_int_s*SLICE_W +: SLICE_W];
        slice_res_s = cla_slice(slice_a_s, slice_b_s, carry_r);
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) next_state_s = RUN;
                else        next_state_s = IDLE;
            end
            RUN: begin
                if (last_s) next_state_s = DONE;
                else        next_state_s = RUN;
            end
            DONE: begin
                if (out_ready) next_state_s = IDLE;
                else           next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register; reset wins over any transfer or acceptance.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Operand capture, per-slice accumulation and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            carry_r   <= 1'b0;
            slice_idx <= IDX_W'(0);
            sum       <= {W{1'b0}};
            cout      <= 1'b0;
`ifdef ADD_SEQ64_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        a_r       <= a;
                        b_r       <= b;
                        carry_r   <= cin;
                        slice_idx <= IDX_W'(0);
                    end
                end
                RUN: begin
                    sum[idx_int_s*SLICE_W +: SLICE_W] <= slice_res_s[SLICE_W-1:0];
                    carry_r <= slice_res_s[SLICE_W];
                    if (last_s) begin
                        slice_idx <= IDX_W'(0);
                        cout      <= slice_res_s[SLICE_W];
`ifdef ADD_SEQ64_OVF_EN
                        // carry into the MSB recovered as a ^ b ^ sum at that bit
                        ovf <= a_r[W-1] ^ b_r[W-1] ^ slice_res_s[SLICE_W-1] ^ slice_res_s[SLICE_W];
`endif
                    end else begin
                        slice_idx <= slice_idx + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE holds the result stable until accepted
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq64.sv
// Self-checking bench for add_seq64: scoreboard queue filled at each transfer,
// drained by a monitor whenever a result is accepted. Build with
// +define+ADD_SEQ64_OVF_EN to also exercise the ovf output.
module tb_add_seq64;
    localparam int SLICE_W = 16;
    localparam int SLICES  = 4;
    localparam int W       = SLICE_W * SLICES;
    localparam int IDX_W   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     sum;
    logic             cout;
`ifdef ADD_SEQ64_OVF_EN
    logic             ovf;
`endif
    logic             busy;
    logic [IDX_W-1:0] slice_idx;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    add_seq64 #(.SLICE_W(SLICE_W), .SLICES(SLICES)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef ADD_SEQ64_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy), .slice_idx(slice_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide integer addition and the signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_unexpected: got result %h with no expected entry", sum);
            end else begin
                e = sb_q.pop_front();
                chk("sum", {1'b0, sum}, {1'b0, e.sum});
                chk("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, e.cout});
`ifdef ADD_SEQ64_OVF_EN
                chk("ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, e.ovf});
`endif
            end
        end
    end

    // Offer one operand set, follow it through RUN and (if out_ready) let it be accepted.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input bit toggle, input bit chk_idx);
        int n;
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_offer", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(model(x, y, c));
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (chk_idx) begin
                chk("busy_run", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
                chk("slice_idx_seq", (W+1)'(slice_idx), (W+1)'(n));
            end
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                a   = {$urandom, $urandom};
                b   = {$urandom, $urandom};
                cin = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", (W+1)'(n), (W+1)'(SLICES));
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk("idle_after_accept", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t         e;
        int           n;
        logic [W-1:0] x;
        logic [W-1:0] y;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = {W{1'b0}}; b = {W{1'b0}}; cin = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, {(W+1){1'b0}});
        chk("rst_out_valid", {{W{1'b0}}, out_valid}, {(W+1){1'b0}});
        chk("rst_busy", {{W{1'b0}}, busy}, {(W+1){1'b0}});
        chk("rst_slice_idx", (W+1)'(slice_idx), {(W+1){1'b0}});
        chk("rst_sum", {1'b0, sum}, {(W+1){1'b0}});
        chk("rst_cout", {{W{1'b0}}, cout}, {(W+1){1'b0}});
`ifdef ADD_SEQ64_OVF_EN
        chk("rst_ovf", {{W{1'b0}}, ovf}, {(W+1){1'b0}});
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});

        // Simple add and full carry ripple with slice index tracking
        issue(64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
        issue({W{1'b1}}, {W{1'b0}}, 1'b1, 1'b0, 1'b1);
`ifdef ADD_SEQ64_OVF_EN
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
`endif

        // Consumer stall: result must be held for five cycles
        out_ready = 1'b0;
        x = 64'h0123_4567_89AB_CDEF;
        y = 64'hFEDC_BA98_7654_3210;
        e = model(x, y, 1'b1);
        issue(x, y, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
            chk("stall_sum", {1'b0, sum}, {1'b0, e.sum});
            chk("stall_cout", {{W{1'b0}}, cout}, {{W{1'b0}}, e.cout});
            chk("stall_in_ready", {{W{1'b0}}, in_ready}, {(W+1){1'b0}});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_idle", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        chk("stall_release_valid", {{W{1'b0}}, out_valid}, {(W+1){1'b0}});

        // Reset in the middle of RUN discards the operation
        @(negedge clk);
        a = 64'hAAAA_5555_AAAA_5555; b = 64'h1111_2222_3333_4444; cin = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        sb_q.push_back(model(a, b, cin));
        #1 in_valid = 1'b0;
        n = 0;
        while (slice_idx != 2'd2 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach_idx2", (W+1)'(slice_idx), (W+1)'(2));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", {{W{1'b0}}, out_valid}, {(W+1){1'b0}});
        chk("abort_busy", {{W{1'b0}}, busy}, {(W+1){1'b0}});
        chk("abort_sum", {1'b0, sum}, {(W+1){1'b0}});
        chk("abort_slice_idx", (W+1)'(slice_idx), {(W+1){1'b0}});
        void'(sb_q.pop_back());
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        issue(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1'b0, 1'b1);

        // in_valid toggling with fresh operands during RUN must be ignored
        issue(64'h8000_0000_0000_0001, 64'h7FFF_0000_1234_FFFF, 1'b0, 1'b1, 1'b0);
        issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b1, 1'b0);

        // Random operands, with boundary patterns mixed in
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0:       x = {W{1'b1}};
                1:       x = {1'b1, {(W-1){1'b0}}};
                default: x = {$urandom, $urandom};
            endcase
            y = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) y = {W{1'b0}};
            issue(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", (W+1)'(sb_q.size()), {(W+1){1'b0}});
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
